regfile_wb_ctrl: RTL and testbench
==================================

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have issue_valid, input, 1, decode requests to issue an instruction.
REQ-004 SHALL have issue_rd/issue_rs_a/issue_rs_b, input, 4 each, destination and source register numbers of the issuing instruction.
REQ-005 SHALL have issue_hazard, output, 1, issue blocked by a pending write (combinational).
REQ-006 SHALL have alu_valid, alu_rd[3:0], alu_data[31:0], inputs; alu_ready, output, 1; ALU writeback channel.
REQ-007 SHALL have mem_valid, mem_rd[3:0], mem_data[31:0], inputs; mem_ready, output, 1; load-unit writeback channel.
REQ-008 SHALL have rf_addr_w, output, 4; rf_data_w, output, 32; rf_write_en, output, 1; the register file write port.
REQ-009 SHALL have busy, output, 16, scoreboard bit per register.

Function
REQ-010 issue_hazard SHALL equal issue_valid & (busy[issue_rs_a] | busy[issue_rs_b] | busy[issue_rd]).
REQ-011 An issue SHALL be accepted when issue_valid & !issue_hazard; if issue_rd != 0, busy[issue_rd] SHALL set on that edge.
REQ-012 busy[0] SHALL be constant 0.
REQ-013 A channel transfer SHALL occur on an edge where valid & ready are both high; ready SHALL be combinational from current valids and arbitration state only.
REQ-014 When exactly one channel is valid, that channel's ready SHALL be high; when neither is valid, both readies SHALL be low.
REQ-015 When both channels are valid, exactly one ready SHALL be high, selected per REQ-024/025.
REQ-016 A transfer with rd != 0 SHALL register rd/data into rf_addr_w/rf_data_w and assert rf_write_en for exactly the following cycle (latency 1).
REQ-017 A transfer with rd == 0 SHALL be accepted and discarded: rf_write_en low next cycle, busy unchanged.
REQ-018 With no transfer, rf_write_en SHALL be low next cycle; rf_addr_w/rf_data_w SHALL hold their previous values.
REQ-019 busy[rf_addr_w] SHALL clear on the edge ending a cycle with rf_write_en high, so busy drops exactly when the register file holds the new value.
REQ-020 If on one edge an issue sets busy[r] and a write clears busy[r], set SHALL win.
REQ-021 Writebacks to a register not marked busy SHALL still be written; busy unaffected.
REQ-022 Sustained throughput SHALL be one register write per cycle.

Reset
REQ-023 While rst_n low: busy = 0, rf_write_en = 0, rf_addr_w = 0, rf_data_w = 0, round-robin pointer = ALU-preferred; any in-flight writeback is dropped; effect immediate, independent of clk.

Configuration
REQ-024 Macro WB_RR_EN defined: round-robin between ALU and MEM; a one-bit last-grant register updates on each transfer; on conflict the channel not granted last wins; first conflict after reset grants ALU.
REQ-025 Macro WB_RR_EN undefined: fixed priority, MEM always wins conflicts; no last-grant register exists.

Verification
REQ-026 Reset, issue rd=3 rs=1/2 -> busy=0x0008 next cycle; issue rs_a=3 -> issue_hazard=1.
REQ-027 alu_valid rd=3 data=0xDEADBEEF -> alu_ready=1; next cycle rf_write_en=1, rf_addr_w=3, rf_data_w=0xDEADBEEF; following cycle busy[3]=0.
REQ-028 Both valid three consecutive cycles (ALU rd=4, MEM rd=5, held until accepted) -> WB_RR_EN: grants ALU,MEM,ALU; without: MEM on every conflict, ALU only after MEM deasserts.
REQ-029 mem_valid rd=0 data=0x12345678 -> mem_ready=1, rf_write_en stays 0, busy unchanged.
REQ-030 rf_write_en high for rd=6 same cycle as accepted issue rd=6 -> busy[6]=1 after edge.
REQ-031 rst_n pulsed low mid-cycle with busy=0x00F0 and transfer pending -> busy=0, rf_write_en=0 immediately, no write after release.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: issue scoreboard plus an ALU/MEM writeback arbiter
// feeding a single registered write port. Define WB_RR_EN for round-robin arbitration.
module regfile_wb_ctrl (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        issue_valid,
  input  logic [3:0]  issue_rd,
  input  logic [3:0]  issue_rs_a,
  input  logic [3:0]  issue_rs_b,
  output logic        issue_hazard,

  input  logic        alu_valid,
  input  logic [3:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,

  input  logic        mem_valid,
  input  logic [3:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,

  output logic [3:0]  rf_addr_w,
  output logic [31:0] rf_data_w,
  output logic        rf_write_en,

  output logic [15:0] busy
);

  logic [15:0] r_busy;
  logic [3:0]  r_addr_w;
  logic [31:0] r_data_w;
  logic        r_write_en;

  logic        w_alu_wins;
  logic        w_alu_xfer;
  logic        w_mem_xfer;
  logic        w_xfer;
  logic [3:0]  w_wb_rd;
  logic [31:0] w_wb_data;
  logic        w_issue_acc;
  logic [15:0] w_busy_next;

`ifdef WB_RR_EN
  // Remembers whether MEM took the most recent transfer; reset value makes ALU win first.
  logic r_last_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_mem <= 1'b1;
    end else if (w_xfer) begin
      r_last_mem <= w_mem_xfer;
    end
  end

  assign w_alu_wins = r_last_mem;
`else
  assign w_alu_wins = 1'b0;
`endif

  assign alu_ready = alu_valid & (~mem_valid | w_alu_wins);
  assign mem_ready = mem_valid & (~alu_valid | ~w_alu_wins);

  assign w_alu_xfer = alu_valid & alu_ready;
  assign w_mem_xfer = mem_valid & mem_ready;
  assign w_xfer     = w_alu_xfer | w_mem_xfer;
  assign w_wb_rd    = w_mem_xfer ? mem_rd   : alu_rd;
  assign w_wb_data  = w_mem_xfer ? mem_data : alu_data;

  assign issue_hazard = issue_valid &
                        (r_busy[issue_rs_a] | r_busy[issue_rs_b] | r_busy[issue_rd]);
  assign w_issue_acc  = issue_valid & ~issue_hazard;

  // Clear applies before set so a same-edge issue to the written register stays busy.
  always_comb begin
    w_busy_next = r_busy;
    if (r_write_en) begin
      w_busy_next[r_addr_w] = 1'b0;
    end
    if (w_issue_acc && (issue_rd != 4'd0)) begin
      w_busy_next[issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 16'h0000;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_en <= 1'b0;
      r_addr_w   <= 4'd0;
      r_data_w   <= 32'd0;
    end else if (w_xfer && (w_wb_rd != 4'd0)) begin
      r_write_en <= 1'b1;
      r_addr_w   <= w_wb_rd;
      r_data_w   <= w_wb_data;
    end else begin
      r_write_en <= 1'b0;
    end
  end

  assign busy        = r_busy;
  assign rf_write_en = r_write_en;
  assign rf_addr_w   = r_addr_w;
  assign rf_data_w   = r_data_w;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios then randomized traffic
// compared against a cycle-level behavioural model. Honours WB_RR_EN like the design.
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [3:0]  issue_rd;
  logic [3:0]  issue_rs_a;
  logic [3:0]  issue_rs_b;
  logic        issue_hazard;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [3:0]  rf_addr_w;
  logic [31:0] rf_data_w;
  logic        rf_write_en;
  logic [15:0] busy;

  int nChecks = 0;
  int nPass   = 0;

  // Behavioural model state.
  localparam int GR_NONE = 0;
  localparam int GR_ALU  = 1;
  localparam int GR_MEM  = 2;
  bit          mBusy[16];
  bit          mWe;
  bit [3:0]    mAddr;
  bit [31:0]   mData;
  int          lastGrant;
  bit          mHazard;
  bit          mAluRdy;
  bit          mMemRdy;

  regfile_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rs_a(issue_rs_a), .issue_rs_b(issue_rs_b), .issue_hazard(issue_hazard),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w), .rf_write_en(rf_write_en),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] modelBusy();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = mBusy[i];
    return v;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 16; i++) mBusy[i] = 1'b0;
    mWe = 1'b0;
    mAddr = 4'd0;
    mData = 32'd0;
    lastGrant = GR_NONE;
  endfunction

  // Combinational expectations derived from the current inputs and model state.
  function automatic void modelComb();
    bit alwaysMem;
    mHazard = issue_valid && (mBusy[issue_rs_a] || mBusy[issue_rs_b] || mBusy[issue_rd]);
`ifdef WB_RR_EN
    alwaysMem = (lastGrant == GR_ALU);
`else
    alwaysMem = 1'b1;
`endif
    if (alu_valid && mem_valid) begin
      mMemRdy = alwaysMem;
      mAluRdy = !alwaysMem;
    end else begin
      mAluRdy = alu_valid;
      mMemRdy = mem_valid;
    end
  endfunction

  function automatic void modelAdvance();
    bit accept;
    bit xfer;
    bit [3:0] rd;
    bit [31:0] data;
    modelComb();
    accept = issue_valid && !mHazard;
    if (mWe) mBusy[mAddr] = 1'b0;
    if (accept && issue_rd != 4'd0) mBusy[issue_rd] = 1'b1;
    xfer = 1'b0;
    rd = 4'd0;
    data = 32'd0;
    if (mAluRdy) begin
      xfer = 1'b1; rd = alu_rd; data = alu_data; lastGrant = GR_ALU;
    end else if (mMemRdy) begin
      xfer = 1'b1; rd = mem_rd; data = mem_data; lastGrant = GR_MEM;
    end
    if (xfer && rd != 4'd0) begin
      mWe = 1'b1; mAddr = rd; mData = data;
    end else begin
      mWe = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic checkAll(input string tag);
    modelComb();
    checkOutput({tag, ".hazard"},  {31'd0, issue_hazard}, {31'd0, mHazard});
    checkOutput({tag, ".aluRdy"},  {31'd0, alu_ready},    {31'd0, mAluRdy});
    checkOutput({tag, ".memRdy"},  {31'd0, mem_ready},    {31'd0, mMemRdy});
    checkOutput({tag, ".busy"},    {16'd0, busy},         {16'd0, modelBusy()});
    checkOutput({tag, ".we"},      {31'd0, rf_write_en},  {31'd0, mWe});
    checkOutput({tag, ".addr"},    {28'd0, rf_addr_w},    {28'd0, mAddr});
    checkOutput({tag, ".data"},    rf_data_w,             mData);
  endtask

  // Check at the falling edge, advance the model, then land 1 time unit after the rising edge.
  task automatic stepCycle(input string tag);
    @(negedge clk);
    checkAll(tag);
    modelAdvance();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit iv, input bit [3:0] ird, input bit [3:0] ra,
                               input bit [3:0] rb, input bit av, input bit [3:0] ard,
                               input bit [31:0] ad, input bit mv, input bit [3:0] mrd,
                               input bit [31:0] md);
    issue_valid = iv; issue_rd = ird; issue_rs_a = ra; issue_rs_b = rb;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idleInputs();
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    bit expAlu[3];
`ifdef WB_RR_EN
    expAlu = '{1'b1, 1'b0, 1'b1};
`else
    expAlu = '{1'b0, 1'b0, 1'b0};
`endif
    rst_n = 1'b0;
    idleInputs();
    modelReset();
    doReset();
    checkOutput("reset.busy", {16'd0, busy}, 32'h0);
    checkOutput("reset.we",   {31'd0, rf_write_en}, 32'h0);
    checkOutput("reset.addr", {28'd0, rf_addr_w}, 32'h0);
    checkOutput("reset.data", rf_data_w, 32'h0);

    // Issue rd=3 sets busy[3]; a reader of r3 is then blocked.
    applyStimulus(1, 3, 1, 2, 0, 0, 0, 0, 0, 0);
    stepCycle("issue3");
    checkOutput("issue3.busy", {16'd0, busy}, 32'h0008);
    applyStimulus(1, 7, 3, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("hazard.rsA", {31'd0, issue_hazard}, 32'h1);
    stepCycle("hazard");

    // ALU writeback of r3: one-cycle latency, then busy clears.
    applyStimulus(0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0);
    #1;
    checkOutput("alu.ready", {31'd0, alu_ready}, 32'h1);
    stepCycle("aluwb");
    idleInputs();
    checkOutput("alu.we",   {31'd0, rf_write_en}, 32'h1);
    checkOutput("alu.addr", {28'd0, rf_addr_w}, 32'h3);
    checkOutput("alu.data", rf_data_w, 32'hDEADBEEF);
    stepCycle("aluwb2");
    checkOutput("alu.busyClr", {16'd0, busy}, 32'h0);

    // MEM writeback to r0 is accepted and discarded.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h12345678);
    #1;
    checkOutput("mem0.ready", {31'd0, mem_ready}, 32'h1);
    stepCycle("mem0");
    idleInputs();
    checkOutput("mem0.we",   {31'd0, rf_write_en}, 32'h0);
    checkOutput("mem0.busy", {16'd0, busy}, 32'h0);

    // Write to non-busy r6 coincides with an accepted issue of r6: set wins.
    applyStimulus(0, 0, 0, 0, 1, 6, 32'hCAFE0006, 0, 0, 0);
    stepCycle("wb6");
    applyStimulus(1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wb6.we", {31'd0, rf_write_en}, 32'h1);
    stepCycle("setwins");
    idleInputs();
    checkOutput("setwins.busy6", {31'd0, busy[6]}, 32'h1);

    // Conflict arbitration from a fresh reset.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 4, 32'hA0 + i, 1, 5, 32'hB0 + i);
      #1;
      checkOutput($sformatf("conflict%0d.alu", i), {31'd0, alu_ready}, {31'd0, expAlu[i]});
      checkOutput($sformatf("conflict%0d.mem", i), {31'd0, mem_ready}, {31'd0, !expAlu[i]});
      stepCycle("conflict");
    end
    applyStimulus(0, 0, 0, 0, 1, 4, 32'hA3, 0, 0, 0);
    #1;
    checkOutput("solo.alu", {31'd0, alu_ready}, 32'h1);
    stepCycle("solo");
    idleInputs();
    stepCycle("drain");

    // Asynchronous reset with busy=0x00F0 and a write pending.
    for (int r = 4; r < 8; r++) begin
      applyStimulus(1, 4'(r), 0, 0, 0, 0, 0, 0, 0, 0);
      stepCycle("fill");
    end
    applyStimulus(0, 0, 0, 0, 1, 4, 32'h44444444, 0, 0, 0);
    stepCycle("pend");
    idleInputs();
    checkOutput("pend.busy", {16'd0, busy}, 32'h00F0);
    checkOutput("pend.we", {31'd0, rf_write_en}, 32'h1);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async.busy", {16'd0, busy}, 32'h0);
    checkOutput("async.we", {31'd0, rf_write_en}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stepCycle("postRst");
    checkOutput("postRst.we", {31'd0, rf_write_en}, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 1), 4'($urandom), 4'($urandom), 4'($urandom),
                    ($urandom_range(0, 2) != 0), 4'($urandom), $urandom,
                    ($urandom_range(0, 2) != 0), 4'($urandom), $urandom);
      stepCycle("rand");
    end
    idleInputs();
    stepCycle("final");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
